qpsk_frame_ctrl: RTL and testbench

Frame scheduler that feeds the QPSK symbol mapper with (bit_I, bit_Q) pairs at symbol rate. Each frame is a fixed preamble taken from a parameter pattern, then a payload pulled from the PRBS source over a valid/ready handshake, then an idle gap. It sits between the PRBS generator and the mapper. It owns the output valid/ready handshake and the frame markers used by the downstream equalizer and sync logic.

---
 rtl/qpsk_pkg.sv | 20 ++
 rtl/qpsk_frame_ctrl.sv | 164 ++++++++++++++++
 tb/tb_qpsk_frame_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/qpsk_pkg.sv
// Shared types and default constants for the QPSK frame scheduler.
// Holds the frame FSM state encoding and the default frame geometry.
// Imported by the frame controller and by anything that decodes its state.
package qpsk_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    GAP      = 2'd3
  } qpsk_state_t;

  localparam int unsigned QPSK_PRE_LEN     = 16;
  localparam int unsigned QPSK_PAY_LEN     = 256;
  localparam int unsigned QPSK_GAP_LEN     = 4;
  localparam logic [31:0] QPSK_PRE_PATTERN = 32'hCCF0_A55A;

  localparam int unsigned QPSK_FRAME_CNT_W = 16;

endpackage

// File: rtl/qpsk_frame_ctrl.sv
// QPSK frame scheduler: preamble from PRE_PATTERN, PRBS payload, idle gap, repeat.
// Latency: 1 cycle from i_enable (or a PRBS pair) to the registered symbol output.
// Backpressure: output register loads only when empty or accepted; PRBS pulled only on a load.
module qpsk_frame_ctrl
  import qpsk_pkg::*;
#(
  parameter int unsigned PRE_LEN     = QPSK_PRE_LEN,
  parameter int unsigned PAY_LEN     = QPSK_PAY_LEN,
  parameter int unsigned GAP_LEN     = QPSK_GAP_LEN,
  parameter logic [31:0] PRE_PATTERN = QPSK_PRE_PATTERN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_enable,
  input  logic                        i_prbs_I,
  input  logic                        i_prbs_Q,
  input  logic                        i_prbs_valid,
  output logic                        o_prbs_ready,
  output logic                        o_bit_I,
  output logic                        o_bit_Q,
  output logic                        o_sym_valid,
  input  logic                        i_sym_ready,
  output logic                        o_sof,
  output logic                        o_eof,
  output logic                        o_busy,
  output logic [QPSK_FRAME_CNT_W-1:0] o_frame_cnt
);

  // Full-width compare targets for the 16-bit phase counters.
  localparam logic [15:0] PRE_LAST = 16'(PRE_LEN - 1);
  localparam logic [15:0] PAY_LAST = 16'(PAY_LEN - 1);
  localparam logic [15:0] GAP_END  = 16'(GAP_LEN);
  localparam logic [QPSK_FRAME_CNT_W-1:0] FCNT_ONE = {{(QPSK_FRAME_CNT_W-1){1'b0}}, 1'b1};

  qpsk_state_t                 r_state;
  logic [15:0]                 r_sym_cnt;
  logic [15:0]                 r_gap_cnt;
  logic                        r_bit_I;
  logic                        r_bit_Q;
  logic                        r_sym_valid;
  logic                        r_sof;
  logic                        r_eof;
  logic [QPSK_FRAME_CNT_W-1:0] r_frame_cnt;

  logic w_load_en;
  logic w_start;
  logic w_pre_I;
  logic w_pre_Q;

  // Output register may take a new symbol when empty or being accepted this cycle.
  assign w_load_en = !r_sym_valid || i_sym_ready;

  // A frame starts from IDLE or from the boundary slot at the end of GAP; both look identical.
  assign w_start = i_enable && w_load_en &&
                   ((r_state == IDLE) || ((r_state == GAP) && (r_gap_cnt == GAP_END)));

  // Preamble symbol n lives in pattern bits [2n+1:2n], I on the odd bit.
  assign w_pre_I = PRE_PATTERN[{r_sym_cnt[3:0], 1'b1}];
  assign w_pre_Q = PRE_PATTERN[{r_sym_cnt[3:0], 1'b0}];

  // PRBS pair is taken exactly when the output register loads during payload.
  assign o_prbs_ready = (r_state == PAYLOAD) && w_load_en;

  assign o_bit_I     = r_bit_I;
  assign o_bit_Q     = r_bit_Q;
  assign o_sym_valid = r_sym_valid;
  assign o_sof       = r_sof;
  assign o_eof       = r_eof;
  assign o_busy      = (r_state != IDLE);
  assign o_frame_cnt = r_frame_cnt;

  // Frame FSM and output holding register in one place so state and symbol never diverge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sym_cnt   <= 16'd0;
      r_gap_cnt   <= 16'd0;
      r_bit_I     <= 1'b0;
      r_bit_Q     <= 1'b0;
      r_sym_valid <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_frame_cnt <= '0;
    end else if (w_start) begin
      r_bit_I     <= PRE_PATTERN[1];
      r_bit_Q     <= PRE_PATTERN[0];
      r_sym_valid <= 1'b1;
      r_sof       <= 1'b1;
      r_eof       <= 1'b0;
      r_gap_cnt   <= 16'd0;
      if (PRE_LAST == 16'd0) begin
        r_state   <= PAYLOAD;
        r_sym_cnt <= 16'd0;
      end else begin
        r_state   <= PREAMBLE;
        r_sym_cnt <= 16'd1;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load_en) begin
            r_sym_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
          end
        end
        PREAMBLE: begin
          if (w_load_en) begin
            r_bit_I     <= w_pre_I;
            r_bit_Q     <= w_pre_Q;
            r_sym_valid <= 1'b1;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            if (r_sym_cnt == PRE_LAST) begin
              r_state   <= PAYLOAD;
              r_sym_cnt <= 16'd0;
            end else begin
              r_sym_cnt <= r_sym_cnt + 16'd1;
            end
          end
        end
        PAYLOAD: begin
          if (w_load_en) begin
            if (i_prbs_valid) begin
              r_bit_I     <= i_prbs_I;
              r_bit_Q     <= i_prbs_Q;
              r_sym_valid <= 1'b1;
              r_sof       <= 1'b0;
              r_eof       <= (r_sym_cnt == PAY_LAST);
              if (r_sym_cnt == PAY_LAST) begin
                r_frame_cnt <= r_frame_cnt + FCNT_ONE;
                r_sym_cnt   <= 16'd0;
                r_gap_cnt   <= 16'd0;
                r_state     <= GAP;
              end else begin
                r_sym_cnt <= r_sym_cnt + 16'd1;
              end
            end else begin
              // Source starved: emit a bubble and keep waiting in payload.
              r_sym_valid <= 1'b0;
              r_sof       <= 1'b0;
              r_eof       <= 1'b0;
            end
          end
        end
        GAP: begin
          // Last symbol drains here; the gap count runs regardless of stalls.
          if (w_load_en) begin
            r_sym_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
          end
          if (r_gap_cnt != GAP_END) begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end else if (!i_enable) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpsk_frame_ctrl.sv
// Scoreboard bench for qpsk_frame_ctrl: directed frames with stall, bubble, disable and reset.
// Expected symbols are queued when a frame is requested; a negedge monitor pops on accept.
// A second instance with minimal frame geometry exercises the frame counter wrap.
module tb_qpsk_frame_ctrl;

  logic        clk;
  logic        rst_n;
  logic        i_enable;
  logic        i_prbs_I;
  logic        i_prbs_Q;
  logic        i_prbs_valid;
  logic        o_prbs_ready;
  logic        o_bit_I;
  logic        o_bit_Q;
  logic        o_sym_valid;
  logic        i_sym_ready;
  logic        o_sof;
  logic        o_eof;
  logic        o_busy;
  logic [15:0] o_frame_cnt;

  logic        w_rst_n;
  logic        w_en;
  logic        w_pI;
  logic        w_pQ;
  logic        w_pvld;
  logic        w_prdy;
  logic        w_I;
  logic        w_Q;
  logic        w_vld;
  logic        w_srdy;
  logic        w_sof;
  logic        w_eof;
  logic        w_busy;
  logic [15:0] w_fcnt;

  int checks = 0;
  int errors = 0;

  qpsk_frame_ctrl #(
    .PRE_LEN(4), .PAY_LEN(8), .GAP_LEN(2), .PRE_PATTERN(32'h0000_001B)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
    .i_prbs_I(i_prbs_I), .i_prbs_Q(i_prbs_Q), .i_prbs_valid(i_prbs_valid),
    .o_prbs_ready(o_prbs_ready), .o_bit_I(o_bit_I), .o_bit_Q(o_bit_Q),
    .o_sym_valid(o_sym_valid), .i_sym_ready(i_sym_ready), .o_sof(o_sof),
    .o_eof(o_eof), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt)
  );

  qpsk_frame_ctrl #(
    .PRE_LEN(1), .PAY_LEN(1), .GAP_LEN(0), .PRE_PATTERN(32'h0000_001B)
  ) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .i_enable(w_en),
    .i_prbs_I(w_pI), .i_prbs_Q(w_pQ), .i_prbs_valid(w_pvld),
    .o_prbs_ready(w_prdy), .o_bit_I(w_I), .o_bit_Q(w_Q),
    .o_sym_valid(w_vld), .i_sym_ready(w_srdy), .o_sof(w_sof),
    .o_eof(w_eof), .o_busy(w_busy), .o_frame_cnt(w_fcnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-picked PRBS pairs {I,Q}; preamble of pattern 0x1B is (1,1),(1,0),(0,1),(0,0).
  logic [1:0] prbs_tab [16] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10, 2'b10,
                                2'b00, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b11};
  logic [1:0] pre_exp  [4]  = '{2'b11, 2'b10, 2'b01, 2'b00};

  logic [3:0] exp_q [$];   // {I, Q, sof, eof}
  logic [3:0] mon_got;
  logic [3:0] mon_exp;
  int         acc_cnt = 0;
  int         pidx = 0;

  logic        s_valid, s_sof, s_eof, s_busy, s_rdy, s_acc;
  logic [1:0]  s_iq;
  logic [15:0] s_fcnt;

  int  acc_start;
  int  c_start;
  bit  saw_sof;
  bit  wrap_done = 0;
  int  eofs = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push_frame(input int base);
    for (int k = 0; k < 4; k++) exp_q.push_back({pre_exp[k], (k == 0), 1'b0});
    for (int k = 0; k < 8; k++) exp_q.push_back({prbs_tab[(base + k) % 16], 1'b0, (k == 7)});
  endtask

  // Sample mid-cycle, then cross the edge and advance the PRBS source if a pair was taken.
  task automatic tick();
    logic fire;
    @(negedge clk);
    fire    = i_prbs_valid && o_prbs_ready;
    s_valid = o_sym_valid;
    s_sof   = o_sof;
    s_eof   = o_eof;
    s_iq    = {o_bit_I, o_bit_Q};
    s_busy  = o_busy;
    s_rdy   = o_prbs_ready;
    s_acc   = o_sym_valid && i_sym_ready;
    s_fcnt  = o_frame_cnt;
    @(posedge clk);
    #1;
    if (fire) pidx++;
    {i_prbs_I, i_prbs_Q} = prbs_tab[pidx % 16];
  endtask

  task automatic wait_mark(input bit want_sof, input string nm);
    bit found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      tick();
      found = s_valid && s_acc && (want_sof ? s_sof : s_eof);
    end
    check(nm, found, 1);
  endtask

  // Scoreboard monitor: every accepted symbol must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && o_sym_valid && i_sym_ready) begin
      acc_cnt++;
      mon_got = {o_bit_I, o_bit_Q, o_sof, o_eof};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sym_unexpected actual=%b required=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL sym_stream actual={I,Q,sof,eof}=%b required=%b", mon_got, mon_exp);
        end
      end
    end
  end

  // Frame counter wrap on a 2-cycle-per-frame instance.
  initial begin
    w_rst_n = 1'b1; w_en = 1'b0; w_pI = 1'b1; w_pQ = 1'b0; w_pvld = 1'b1; w_srdy = 1'b1;
    #2 w_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    w_rst_n = 1'b1;
    w_en    = 1'b1;
    for (int c = 0; c < 140000 && eofs < 65537; c++) begin
      @(negedge clk);
      if (w_vld && w_eof) begin
        eofs++;
        if (eofs == 65535) check("wrap_ffff", w_fcnt, 16'hFFFF);
        if (eofs == 65536) check("wrap_0000", w_fcnt, 16'h0000);
        if (eofs == 65537) check("wrap_0001", w_fcnt, 16'h0001);
      end
    end
    check("wrap_frames", eofs, 65537);
    w_en      = 1'b0;
    wrap_done = 1'b1;
  end

  initial begin
    rst_n = 1'b1; i_enable = 1'b0; i_prbs_valid = 1'b1; i_sym_ready = 1'b1;
    {i_prbs_I, i_prbs_Q} = prbs_tab[0];
    #2 rst_n = 1'b0;
    #10;
    check("rst_valid", o_sym_valid, 0);
    check("rst_sof_eof", {o_sof, o_eof}, 0);
    check("rst_iq", {o_bit_I, o_bit_Q}, 0);
    check("rst_busy_rdy", {o_busy, o_prbs_ready}, 0);
    check("rst_fcnt", o_frame_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick();
    check("idle_valid", s_valid, 0);

    // Frame A: continuous flow, 1-cycle start latency, gap of two empty cycles.
    push_frame(pidx);
    i_enable = 1'b1;
    tick(); tick();
    check("start_latency", {s_valid, s_sof}, 2'b11);
    wait_mark(0, "a_eof");
    check("a_fcnt", s_fcnt, 1);
    push_frame(pidx);
    tick(); check("gap0_valid", s_valid, 0);
    tick(); check("gap1_valid", s_valid, 0);
    tick(); check("next_sof", {s_valid, s_sof}, 2'b11);
    acc_start = acc_cnt - 1;

    // Frame B: downstream stall while preamble symbol 2 is presented.
    tick();
    i_sym_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_hold", {s_valid, s_iq, s_sof}, 4'b1010);
    end
    i_sym_ready = 1'b1;
    wait_mark(0, "b_eof");
    check("b_accepted", acc_cnt - acc_start, 12);
    check("b_fcnt", s_fcnt, 2);
    push_frame(pidx);

    // Frame C: source starves for 3 cycles at payload symbol 4.
    wait_mark(1, "c_sof");
    c_start = pidx;
    repeat (6) tick();
    i_prbs_valid = 1'b0;
    tick();
    check("bubble_rdy0", {s_rdy, s_valid}, 2'b11);
    tick();
    check("bubble_1", {s_rdy, s_valid, s_busy}, 3'b101);
    tick();
    check("bubble_2", {s_rdy, s_valid, s_busy}, 3'b101);
    i_prbs_valid = 1'b1;
    wait_mark(0, "c_eof");
    check("c_pairs", pidx - c_start, 8);
    check("c_fcnt", s_fcnt, 3);
    push_frame(pidx);

    // Frame D: enable dropped mid-payload; frame completes then controller idles.
    wait_mark(1, "d_sof");
    repeat (5) tick();
    i_enable = 1'b0;
    wait_mark(0, "d_eof");
    check("d_fcnt", s_fcnt, 4);
    saw_sof = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (s_valid && s_sof) saw_sof = 1;
    end
    check("d_no_sof", saw_sof, 0);
    check("d_idle", {s_busy, s_valid}, 2'b00);
    check("d_fcnt_hold", s_fcnt, 4);

    // Frame E: reset pulse at preamble symbol 3 aborts, fresh frame after release.
    push_frame(pidx);
    i_enable = 1'b1;
    wait_mark(1, "e_sof");
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("arst_valid", {o_sym_valid, o_sof, o_eof}, 0);
    check("arst_iq", {o_bit_I, o_bit_Q}, 0);
    check("arst_busy_rdy", {o_busy, o_prbs_ready}, 0);
    check("arst_fcnt", o_frame_cnt, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_frame(pidx);
    wait_mark(1, "f_sof");
    check("f_first_iq", s_iq, 2'b11);
    check("f_fcnt0", s_fcnt, 0);
    wait_mark(0, "f_eof");
    check("f_fcnt1", s_fcnt, 1);
    i_enable = 1'b0;
    repeat (6) tick();
    check("queue_drained", exp_q.size(), 0);

    wait (wrap_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
